mem_stage: RTL

Memory-access stage of the pipelined core, directly downstream of the EXE ALU. It consumes the ALU result as the effective address, or as a pass-through value, plus the store operand. It runs one load/store at a time over a req/ack data-memory handshake and stalls the upstream pipeline while the access is outstanding. It delivers a registered, formatted result to write-back.

---
 rtl/mem_stage_if.sv | 50 +++++
 rtl/mem_stage.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/mem_stage_if.sv
// mem_stage_if: pipeline-side and data-memory-side signals of the memory stage.
// master = environment (upstream pipeline + data memory), slave = mem_stage.
// io_misaligned_MEM exists only when MEM_MISALIGN_TRAP_EN is defined.
interface mem_stage_if;
  logic        io_valid_MEM;
  logic [3:0]  io_memOP_ctrl_uMEM_MEM;
  logic [31:0] io_aluResult_MEM;
  logic [31:0] io_storeData_MEM;
  logic        io_stall_MEM;
  logic [31:0] io_result_MEM;
  logic        io_resultValid_MEM;
  logic        io_dmemReq;
  logic        io_dmemWe;
  logic [31:0] io_dmemAddr;
  logic [31:0] io_dmemWdata;
  logic [3:0]  io_dmemWstrb;
  logic        io_dmemAck;
  logic [31:0] io_dmemRdata;
`ifdef MEM_MISALIGN_TRAP_EN
  logic        io_misaligned_MEM;

  modport master (
    output io_valid_MEM, io_memOP_ctrl_uMEM_MEM, io_aluResult_MEM, io_storeData_MEM,
           io_dmemAck, io_dmemRdata,
    input  io_stall_MEM, io_result_MEM, io_resultValid_MEM, io_dmemReq, io_dmemWe,
           io_dmemAddr, io_dmemWdata, io_dmemWstrb, io_misaligned_MEM
  );

  modport slave (
    input  io_valid_MEM, io_memOP_ctrl_uMEM_MEM, io_aluResult_MEM, io_storeData_MEM,
           io_dmemAck, io_dmemRdata,
    output io_stall_MEM, io_result_MEM, io_resultValid_MEM, io_dmemReq, io_dmemWe,
           io_dmemAddr, io_dmemWdata, io_dmemWstrb, io_misaligned_MEM
  );
`else
  modport master (
    output io_valid_MEM, io_memOP_ctrl_uMEM_MEM, io_aluResult_MEM, io_storeData_MEM,
           io_dmemAck, io_dmemRdata,
    input  io_stall_MEM, io_result_MEM, io_resultValid_MEM, io_dmemReq, io_dmemWe,
           io_dmemAddr, io_dmemWdata, io_dmemWstrb
  );

  modport slave (
    input  io_valid_MEM, io_memOP_ctrl_uMEM_MEM, io_aluResult_MEM, io_storeData_MEM,
           io_dmemAck, io_dmemRdata,
    output io_stall_MEM, io_result_MEM, io_resultValid_MEM, io_dmemReq, io_dmemWe,
           io_dmemAddr, io_dmemWdata, io_dmemWstrb
  );
`endif
endinterface

// File: rtl/mem_stage.sv
// mem_stage: memory-access pipeline stage. One load/store at a time over a
// req/ack data-memory handshake, upstream stalled while the access is open,
// registered formatted result to write-back.
// Optional: MEM_MISALIGN_TRAP_EN turns misaligned half/word accesses into a
// one-cycle trap strobe instead of a memory request.
module mem_stage (
  input logic      clock,
  input logic      reset,
  mem_stage_if.slave bus
);

  typedef enum logic [1:0] {IDLE, REQ, RESP} state_t;
  typedef enum logic [3:0] {
    OP_NONE = 4'd0, OP_LB = 4'd1, OP_LH = 4'd2, OP_LW = 4'd3, OP_LBU = 4'd4,
    OP_LHU = 4'd5, OP_SB = 4'd6, OP_SH = 4'd7, OP_SW = 4'd8
  } op_t;

  state_t      state, state_next;
  op_t         op_in, op_q;
  logic [1:0]  lane_q;
  logic [31:0] addr_q, wdata_q, result_q;
  logic [3:0]  wstrb_q;
  logic        we_q, rv_q;
  logic        in_mem, in_misaligned, accept, req, stall;
  logic [31:0] wdata_d, load_data;
  logic [3:0]  wstrb_d;
  logic        we_d;
  logic [7:0]  rd_byte;
  logic [15:0] rd_half;

  assign op_in = op_t'(bus.io_memOP_ctrl_uMEM_MEM);

  // Decode the incoming op and pre-format store lanes/strobes.
  always_comb begin
    in_mem        = 1'b0;
    in_misaligned = 1'b0;
    wdata_d       = '0;
    wstrb_d       = '0;
    we_d          = 1'b0;
    case (op_in)
      OP_LB, OP_LBU: in_mem = 1'b1;
      OP_LH, OP_LHU: begin
        in_mem = 1'b1;
`ifdef MEM_MISALIGN_TRAP_EN
        in_misaligned = bus.io_aluResult_MEM[0];
`endif
      end
      OP_LW: begin
        in_mem = 1'b1;
`ifdef MEM_MISALIGN_TRAP_EN
        in_misaligned = |bus.io_aluResult_MEM[1:0];
`endif
      end
      OP_SB: begin
        in_mem  = 1'b1;
        we_d    = 1'b1;
        wdata_d = {4{bus.io_storeData_MEM[7:0]}};
        wstrb_d = 4'b0001 << bus.io_aluResult_MEM[1:0];
      end
      OP_SH: begin
        in_mem  = 1'b1;
        we_d    = 1'b1;
        wdata_d = {2{bus.io_storeData_MEM[15:0]}};
        wstrb_d = 4'b0011 << {bus.io_aluResult_MEM[1], 1'b0};
`ifdef MEM_MISALIGN_TRAP_EN
        in_misaligned = bus.io_aluResult_MEM[0];
`endif
      end
      OP_SW: begin
        in_mem  = 1'b1;
        we_d    = 1'b1;
        wdata_d = bus.io_storeData_MEM;
        wstrb_d = 4'b1111;
`ifdef MEM_MISALIGN_TRAP_EN
        in_misaligned = |bus.io_aluResult_MEM[1:0];
`endif
      end
      default: ;
    endcase
  end

  assign accept = (state == IDLE) && bus.io_valid_MEM && in_mem && !in_misaligned;

  // State register.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  // Next-state logic and handshake/stall outputs.
  always_comb begin
    state_next = state;
    req        = 1'b0;
    stall      = 1'b0;
    case (state)
      IDLE: begin
        stall = accept;
        if (accept) state_next = REQ;
      end
      REQ: begin
        req   = 1'b1;
        stall = 1'b1;
        if (bus.io_dmemAck) state_next = RESP;
      end
      RESP:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Extract and extend the addressed lane of the returned word.
  always_comb begin
    rd_byte   = bus.io_dmemRdata[{lane_q, 3'b000} +: 8];
    rd_half   = lane_q[1] ? bus.io_dmemRdata[31:16] : bus.io_dmemRdata[15:0];
    load_data = '0;
    case (op_q)
      OP_LB:   load_data = {{24{rd_byte[7]}}, rd_byte};
      OP_LBU:  load_data = {24'd0, rd_byte};
      OP_LH:   load_data = {{16{rd_half[15]}}, rd_half};
      OP_LHU:  load_data = {16'd0, rd_half};
      OP_LW:   load_data = bus.io_dmemRdata;
      default: load_data = '0;
    endcase
  end

  // Latch the accepted access and produce the registered write-back result.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      op_q     <= OP_NONE;
      lane_q   <= '0;
      addr_q   <= '0;
      wdata_q  <= '0;
      wstrb_q  <= '0;
      we_q     <= 1'b0;
      result_q <= '0;
      rv_q     <= 1'b0;
    end else begin
      rv_q <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            op_q    <= op_in;
            lane_q  <= bus.io_aluResult_MEM[1:0];
            addr_q  <= {bus.io_aluResult_MEM[31:2], 2'b00};
            wdata_q <= wdata_d;
            wstrb_q <= wstrb_d;
            we_q    <= we_d;
          end else if (bus.io_valid_MEM) begin
            // Pass-through and trapped misaligned ops both return the ALU value.
            result_q <= bus.io_aluResult_MEM;
            rv_q     <= 1'b1;
          end
        end
        REQ: begin
          if (bus.io_dmemAck) begin
            result_q <= we_q ? '0 : load_data;
            rv_q     <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

`ifdef MEM_MISALIGN_TRAP_EN
  logic mis_q;

  // One-cycle misalignment strobe alongside the trapped result.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) mis_q <= 1'b0;
    else       mis_q <= (state == IDLE) && bus.io_valid_MEM && in_mem && in_misaligned;
  end

  assign bus.io_misaligned_MEM = mis_q;
`endif

  assign bus.io_stall_MEM       = stall;
  assign bus.io_result_MEM      = result_q;
  assign bus.io_resultValid_MEM = rv_q;
  assign bus.io_dmemReq         = req;
  assign bus.io_dmemWe          = we_q & req;
  assign bus.io_dmemAddr        = addr_q;
  assign bus.io_dmemWdata       = wdata_q;
  assign bus.io_dmemWstrb       = wstrb_q;

endmodule
